// File: rtl/muldiv_unit.sv
`default_nettype none
// ============================================================================
// Module   : muldiv_unit
// Purpose  : Iterative RV32M multiply/divide unit. One shared 32-iteration
//            engine does shift-add multiply and restoring divide on operand
//            magnitudes. The sign is fixed up in a final SIGN cycle.
// Ports    : clk, rst      - clock, synchronous active-high reset
//            start         - request, accepted only in IDLE or DONE
//            funct3[2:0]   - RV32M operation select
//            op_a, op_b    - rs1 / rs2 operand values
//            busy          - operation in flight (CALC or SIGN)
//            done          - one-cycle pulse, result valid
//            result[31:0]  - registered result, held until replaced
// Revision : 1.0 - initial release
// ============================================================================
module muldiv_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [2:0]  funct3,
  input  logic [31:0] op_a,
  input  logic [31:0] op_b,
  output logic        busy,
  output logic        done,
  output logic [31:0] result
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_SIGN = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  logic [1:0]  state_q,  state_d;
  logic [4:0]  cnt_q,    cnt_d;
  logic [2:0]  f3_q,     f3_d;
  logic [63:0] acc_q,    acc_d;    // mul: {partial hi, multiplier/product lo}; div: {remainder, dividend/quotient}
  logic [31:0] opb_q,    opb_d;    // mul: multiplicand magnitude; div: divisor magnitude
  logic        neg_q,    neg_d;    // negate the engine output in SIGN
  logic [31:0] result_q, result_d;

  logic        a_signed, b_signed, sa, sb;
  logic [31:0] mag_a, mag_b;
  logic        is_div, div_zero, div_ovf, accept;
  logic [32:0] mul_sum;
  logic [63:0] mul_next;
  logic [32:0] shifted;
  logic        ge;
  logic [31:0] diff, rem_next;
  logic [63:0] div_next;
  logic [63:0] prod;
  logic [31:0] quot, remv;
  logic [31:0] sign_val;

  always_comb begin
    a_signed = (funct3 == 3'b000) || (funct3 == 3'b001) || (funct3 == 3'b010) ||
               (funct3 == 3'b100) || (funct3 == 3'b110);
    b_signed = (funct3 == 3'b000) || (funct3 == 3'b001) ||
               (funct3 == 3'b100) || (funct3 == 3'b110);
    sa       = a_signed & op_a[31];
    sb       = b_signed & op_b[31];
    mag_a    = sa ? (~op_a + 32'd1) : op_a;
    mag_b    = sb ? (~op_b + 32'd1) : op_b;
    is_div   = funct3[2];
    div_zero = is_div && (op_b == 32'd0);
    div_ovf  = is_div && !funct3[0] && (op_a == 32'h8000_0000) && (op_b == 32'hFFFF_FFFF);
    accept   = start && ((state_q == S_IDLE) || (state_q == S_DONE));

    // Shift-add step: add multiplicand into the high half when the current
    // multiplier LSB is set, then shift the 65-bit {carry, acc} right by one.
    mul_sum  = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, opb_q} : 33'd0);
    mul_next = {mul_sum, acc_q[31:1]};

    // Restoring divide step: shift the next dividend bit into the partial
    // remainder; the 33rd bit catches a partial that momentarily exceeds 32 bits.
    shifted  = {acc_q[63:32], acc_q[31]};
    ge       = (shifted >= {1'b0, opb_q});
    diff     = shifted[31:0] - opb_q;
    rem_next = ge ? diff : shifted[31:0];
    div_next = {rem_next, acc_q[30:0], ge};

    prod     = neg_q ? (~acc_q + 64'd1) : acc_q;
    quot     = neg_q ? (~acc_q[31:0] + 32'd1) : acc_q[31:0];
    remv     = neg_q ? (~acc_q[63:32] + 32'd1) : acc_q[63:32];
    case (f3_q)
      3'b000:          sign_val = prod[31:0];
      3'b001, 3'b010,
      3'b011:          sign_val = prod[63:32];
      3'b100, 3'b101:  sign_val = quot;
      default:         sign_val = remv;
    endcase

    state_d  = state_q;
    cnt_d    = cnt_q;
    f3_d     = f3_q;
    acc_d    = acc_q;
    opb_d    = opb_q;
    neg_d    = neg_q;
    result_d = result_q;

    case (state_q)
      S_CALC: begin
        acc_d = f3_q[2] ? div_next : mul_next;
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == 5'd31) state_d = S_SIGN;
      end
      S_SIGN: begin
        result_d = sign_val;
        state_d  = S_DONE;
      end
      default: begin  // S_IDLE, S_DONE
        state_d = S_IDLE;
        if (accept) begin
          f3_d = funct3;
          if (div_zero) begin
            result_d = funct3[1] ? op_a : 32'hFFFF_FFFF;
            state_d  = S_DONE;
          end else if (div_ovf) begin
            result_d = funct3[1] ? 32'd0 : 32'h8000_0000;
            state_d  = S_DONE;
          end else begin
            state_d = S_CALC;
            cnt_d   = 5'd0;
            // Remainder takes the dividend's sign; everything else sa^sb.
            neg_d   = (is_div && funct3[1]) ? sa : (sa ^ sb);
            acc_d   = is_div ? {32'd0, mag_a} : {32'd0, mag_b};
            opb_d   = is_div ? mag_b : mag_a;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= 5'd0;
      f3_q     <= 3'd0;
      acc_q    <= 64'd0;
      opb_q    <= 32'd0;
      neg_q    <= 1'b0;
      result_q <= 32'd0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      f3_q     <= f3_d;
      acc_q    <= acc_d;
      opb_q    <= opb_d;
      neg_q    <= neg_d;
      result_q <= result_d;
    end
  end

  assign busy   = (state_q == S_CALC) || (state_q == S_SIGN);
  assign done   = (state_q == S_DONE);
  assign result = result_q;

endmodule
`default_nettype wire

// File: tb/tb_muldiv_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_muldiv_unit
// Purpose  : Scoreboard bench for muldiv_unit. Issued operations push their
//            expected result and done cycle; a monitor compares busy, done
//            and result every cycle against that expectation.
// Revision : 1.0 - initial release
// ============================================================================
module tb_muldiv_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [2:0]  funct3 = 3'd0;
  logic [31:0] op_a = 32'd0;
  logic [31:0] op_b = 32'd0;
  logic        busy, done;
  logic [31:0] result;

  muldiv_unit dut (
    .clk(clk), .rst(rst), .start(start), .funct3(funct3),
    .op_a(op_a), .op_b(op_b), .busy(busy), .done(done), .result(result)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] res;
    int          due;
  } exp_t;

  exp_t sb[$];
  int busy_from = -1;
  int busy_to   = -2;
  int n_checks  = 0;
  int n_pass    = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %08h expected %08h (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic timeout(input string name);
    n_checks++;
    $display("FAIL %s: timed out waiting for DUT (cycle %0d)", name, cyc);
  endtask

  // Reference model: plain 64-bit arithmetic on sign/zero-extended operands.
  function automatic bit is_special(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    return f[2] && ((b == 32'd0) || (!f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF));
  endfunction

  function automatic logic [31:0] ref_res(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    logic signed [63:0] as_, bs_, bz, ps;
    logic        [63:0] au, bu, pu;
    as_ = {{32{a[31]}}, a};
    bs_ = {{32{b[31]}}, b};
    au  = {32'd0, a};
    bu  = {32'd0, b};
    bz  = {32'd0, b};
    case (f)
      3'b000: begin ps = as_ * bs_; return ps[31:0];  end
      3'b001: begin ps = as_ * bs_; return ps[63:32]; end
      3'b010: begin ps = as_ * bz;  return ps[63:32]; end
      3'b011: begin pu = au * bu;   return pu[63:32]; end
      3'b100: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
        ps = as_ / bs_; return ps[31:0];
      end
      3'b101: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'b110: begin
        if (b == 0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
        ps = as_ % bs_; return ps[31:0];
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  // Monitor: samples on the falling edge; the driver moves 1 ns later.
  always @(negedge clk) begin
    if (cyc >= 2) begin
      logic exp_busy, exp_done;
      exp_busy = (cyc >= busy_from) && (cyc <= busy_to);
      exp_done = (sb.size() > 0) && (sb[0].due == cyc);
      chk("busy", {31'd0, busy}, {31'd0, exp_busy});
      chk("done", {31'd0, done}, {31'd0, exp_done});
      if (exp_done) begin
        exp_t e;
        e = sb.pop_front();
        if (done) chk("result", result, e.res);
      end
    end
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic issue(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    bit   sp;
    sp     = is_special(f, a, b);
    funct3 = f;
    op_a   = a;
    op_b   = b;
    start  = 1'b1;
    e.res  = ref_res(f, a, b);
    e.due  = cyc + (sp ? 1 : 34);
    sb.push_back(e);
    if (!sp) begin
      busy_from = cyc + 1;
      busy_to   = cyc + 33;
    end
    step();
    start  = 1'b0;
    funct3 = 3'($urandom);
    op_a   = $urandom;
    op_b   = $urandom;
  endtask

  task automatic wait_done();
    for (int k = 0; k < 100; k++) begin
      if (done) return;
      step();
    end
    timeout("wait_done");
  endtask

  task automatic wait_idle();
    for (int k = 0; k < 100; k++) begin
      if (sb.size() == 0) return;
      step();
    end
    timeout("wait_idle");
    sb.delete();
  endtask

  function automatic logic [31:0] pick(input bit allow_zero);
    case ($urandom_range(0, 5))
      0: return 32'h8000_0000;
      1: return 32'hFFFF_FFFF;
      2: return 32'($urandom_range(0, 20));
      3: return allow_zero ? 32'd0 : 32'd1;
      default: return $urandom;
    endcase
  endfunction

  logic [2:0]  dir_f [14] = '{3'b000, 3'b011, 3'b001, 3'b010, 3'b011, 3'b100, 3'b110,
                             3'b101, 3'b111, 3'b100, 3'b111, 3'b100, 3'b110, 3'b000};
  logic [31:0] dir_a [14] = '{32'd7, 32'hFFFF_FFFF, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000,
                             32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'd100, 32'd100, 32'd5, 32'd5,
                             32'h8000_0000, 32'h8000_0000, 32'hFFFF_FFFF};
  logic [31:0] dir_b [14] = '{32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'h8000_0000, 32'hFFFF_FFFF, 32'd2,
                             32'd2, 32'd2, 32'd7, 32'd7, 32'd0, 32'd0,
                             32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF};

  initial begin
    repeat (3) step();
    chk("reset_busy", {31'd0, busy}, 32'd0);
    chk("reset_done", {31'd0, done}, 32'd0);
    chk("reset_result", result, 32'd0);
    rst = 1'b0;
    step();

    // Directed cases from the operation table
    for (int i = 0; i < 14; i++) begin
      issue(dir_f[i], dir_a[i], dir_b[i]);
      wait_idle();
      step();
    end

    // start held high through CALC with changing operands must be ignored
    issue(3'b000, 32'd12345, 32'hFFFF_FF00);
    for (int i = 0; i < 28; i++) begin
      start  = 1'b1;
      funct3 = 3'($urandom);
      op_a   = $urandom;
      op_b   = $urandom;
      step();
    end
    start = 1'b0;
    wait_idle();
    step();

    // Back-to-back: second start in the DONE cycle
    issue(3'b101, 32'd1000, 32'd33);
    wait_done();
    issue(3'b001, 32'hDEAD_BEEF, 32'h1234_5678);
    wait_done();
    issue(3'b100, 32'd9, 32'd0);
    wait_done();
    step();

    // Reset in the middle of an operation
    issue(3'b101, 32'd100, 32'd7);
    repeat (9) step();
    rst = 1'b1;
    sb.delete();
    busy_to = -2;
    step();
    chk("midreset_busy", {31'd0, busy}, 32'd0);
    chk("midreset_done", {31'd0, done}, 32'd0);
    chk("midreset_result", result, 32'd0);
    rst = 1'b0;
    repeat (40) step();
    issue(3'b110, 32'd100, 32'd7);
    wait_idle();
    step();

    // Randomized operations, mixing back-to-back and idle gaps
    for (int i = 0; i < 50; i++) begin
      issue(3'($urandom_range(0, 7)), pick(1'b0), pick(1'b1));
      wait_done();
      if ($urandom_range(0, 1) == 1) repeat ($urandom_range(1, 3)) step();
    end
    wait_idle();
    repeat (3) step();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1);
  end

endmodule
`default_nettype wire
